// File: rtl/seq_calc_pkg.sv
// rtl/seq_calc_pkg.sv - shared enums and seed constants for the sequence calculator
package seq_calc_pkg;

  typedef enum logic [1:0] {
    MODE_FIB    = 2'b00,
    MODE_LUCAS  = 2'b01,
    MODE_PELL   = 2'b10,
    MODE_CUSTOM = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_COMPUTE = 2'b01,
    ST_DONE    = 2'b10
  } state_e;

  localparam int unsigned FIB_S0   = 0;
  localparam int unsigned FIB_S1   = 1;
  localparam int unsigned LUCAS_S0 = 2;
  localparam int unsigned LUCAS_S1 = 1;
  localparam int unsigned PELL_S0  = 0;
  localparam int unsigned PELL_S1  = 1;

endpackage

// File: rtl/seq_step.sv
// rtl/seq_step.sv - one recurrence step: next_a = m*a + b with carry-out detection
module seq_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             pell_i,
  output logic [WIDTH-1:0] next_a_o,
  output logic             overflow_o
);

  logic [WIDTH+1:0] m_a;
  logic [WIDTH+1:0] sum;

  // Two guard bits cover the worst case 2*a + b.
  assign m_a        = pell_i ? {1'b0, a_i, 1'b0} : {2'b00, a_i};
  assign sum        = m_a + {2'b00, b_i};
  assign next_a_o   = sum[WIDTH-1:0];
  assign overflow_o = |sum[WIDTH+1:WIDTH];

endmodule

// File: rtl/sequence_calculator.sv
// rtl/sequence_calculator.sv - iterative Fibonacci/Lucas/Pell/custom term calculator
module sequence_calculator
  import seq_calc_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int N_WIDTH = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         mode,
  input  logic [N_WIDTH-1:0] n,
  input  logic [WIDTH-1:0]   seed0,
  input  logic [WIDTH-1:0]   seed1,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               overflow
);

  state_e               state_q, state_d;
  mode_e                mode_q, mode_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
  logic [N_WIDTH-1:0]   cnt_q, cnt_d;
  logic                 acc_q, acc_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 overflow_q, overflow_d;
  logic [WIDTH-1:0]     s0, s1;
  logic [WIDTH-1:0]     step_a;
  logic                 step_ovf;

  seq_step #(.WIDTH(WIDTH)) u_step (
    .a_i       (a_q),
    .b_i       (b_q),
    .pell_i    (mode_q == MODE_PELL),
    .next_a_o  (step_a),
    .overflow_o(step_ovf)
  );

  always_comb begin
    s0 = WIDTH'(FIB_S0);
    s1 = WIDTH'(FIB_S1);
    case (mode_e'(mode))
      MODE_LUCAS:  begin s0 = WIDTH'(LUCAS_S0); s1 = WIDTH'(LUCAS_S1); end
      MODE_PELL:   begin s0 = WIDTH'(PELL_S0);  s1 = WIDTH'(PELL_S1);  end
      MODE_CUSTOM: begin s0 = seed0;            s1 = seed1;            end
      default:     begin s0 = WIDTH'(FIB_S0);   s1 = WIDTH'(FIB_S1);   end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    a_d        = a_q;
    b_d        = b_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d  = mode_e'(mode);
          a_d     = s1;
          b_d     = s0;
          cnt_d   = n;
          acc_d   = 1'b0;
          state_d = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        // Abort wins over completion so a cancelled run never reports.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cnt_q <= N_WIDTH'(1)) begin
          state_d    = ST_DONE;
          result_d   = (cnt_q == '0) ? b_q : a_q;
          overflow_d = acc_q;
        end else begin
          a_d   = step_a;
          b_d   = a_q;
          cnt_d = cnt_q - N_WIDTH'(1);
          acc_d = acc_q | step_ovf;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_FIB;
      a_q        <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
      acc_q      <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = (state_q == ST_COMPUTE);
  assign done     = (state_q == ST_DONE);
  assign result   = result_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_sequence_calculator.sv
// tb/tb_sequence_calculator.sv - directed self-checking bench for sequence_calculator
module tb_sequence_calculator;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [1:0]  mode;
  logic [4:0]  n;
  logic [15:0] seed0, seed1;
  logic        busy, done, overflow;
  logic [15:0] result;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sequence_calculator #(.WIDTH(16), .N_WIDTH(5)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .abort   (abort),
    .mode    (mode),
    .n       (n),
    .seed0   (seed0),
    .seed1   (seed1),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .overflow(overflow)
  );

  // Launches one run, scrambles the don't-care inputs, waits for done (bounded).
  task automatic do_run(input logic [1:0] m, input logic [4:0] nn,
                        input logic [15:0] s0, input logic [15:0] s1,
                        output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1; mode = m; n = nn; seed0 = s0; seed1 = s1;
    @(negedge clk);
    start = 1'b0; mode = ~m; n = ~nn; seed0 = ~s0; seed1 = ~s1;
    lat = 0; bcnt = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'b00; n = '0; seed0 = '0; seed1 = '0;
    repeat (2) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
    vectors++; if (result !== 16'd0) begin miscompares++; $display("FAIL reset_result: got %0d expected 0", result); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    reset = 1'b0;
  endtask

  task automatic test_fibonacci();
    int lat, bcnt;
    do_run(2'b00, 5'd10, 16'hdead, 16'hbeef, lat, bcnt);
    vectors++; if (result !== 16'd55) begin miscompares++; $display("FAIL fib10_result: got %0d expected 55", result); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL fib10_overflow: got %b expected 0", overflow); end
    vectors++; if (lat != 10) begin miscompares++; $display("FAIL fib10_latency: got %0d expected 10", lat); end
    vectors++; if (bcnt != 10) begin miscompares++; $display("FAIL fib10_busy_cycles: got %0d expected 10", bcnt); end
    do_run(2'b00, 5'd0, 16'h1234, 16'h5678, lat, bcnt);
    vectors++; if (result !== 16'd0) begin miscompares++; $display("FAIL fib0_result: got %0d expected 0", result); end
    vectors++; if (lat != 1) begin miscompares++; $display("FAIL fib0_latency: got %0d expected 1", lat); end
    do_run(2'b00, 5'd1, 16'h1234, 16'h5678, lat, bcnt);
    vectors++; if (result !== 16'd1) begin miscompares++; $display("FAIL fib1_result: got %0d expected 1", result); end
    vectors++; if (lat != 1) begin miscompares++; $display("FAIL fib1_latency: got %0d expected 1", lat); end
  endtask

  task automatic test_other_modes();
    int lat, bcnt;
    do_run(2'b01, 5'd5, 16'h00ff, 16'h0f0f, lat, bcnt);
    vectors++; if (result !== 16'd11) begin miscompares++; $display("FAIL lucas5_result: got %0d expected 11", result); end
    vectors++; if (lat != 5) begin miscompares++; $display("FAIL lucas5_latency: got %0d expected 5", lat); end
    do_run(2'b10, 5'd6, 16'h00ff, 16'h0f0f, lat, bcnt);
    vectors++; if (result !== 16'd70) begin miscompares++; $display("FAIL pell6_result: got %0d expected 70", result); end
    do_run(2'b11, 5'd3, 16'd3, 16'd4, lat, bcnt);
    vectors++; if (result !== 16'd11) begin miscompares++; $display("FAIL custom3_result: got %0d expected 11", result); end
    do_run(2'b11, 5'd0, 16'd3, 16'd4, lat, bcnt);
    vectors++; if (result !== 16'd3) begin miscompares++; $display("FAIL custom0_result: got %0d expected 3", result); end
  endtask

  task automatic test_overflow();
    int lat, bcnt;
    do_run(2'b00, 5'd25, 16'h0, 16'h0, lat, bcnt);
    vectors++; if (result !== 16'd9489) begin miscompares++; $display("FAIL fib25_result: got %0d expected 9489", result); end
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL fib25_overflow: got %b expected 1", overflow); end
    do_run(2'b00, 5'd24, 16'h0, 16'h0, lat, bcnt);
    vectors++; if (result !== 16'd46368) begin miscompares++; $display("FAIL fib24_result: got %0d expected 46368", result); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL fib24_overflow: got %b expected 0", overflow); end
    repeat (3) @(negedge clk);
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL done_pulse_width: got %b expected 0", done); end
    vectors++; if (result !== 16'd46368) begin miscompares++; $display("FAIL result_hold: got %0d expected 46368", result); end
  endtask

  task automatic test_abort();
    int seen;
    @(negedge clk); start = 1'b1; mode = 2'b00; n = 5'd20;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b expected 0", busy); end
    vectors++; if (result !== 16'd46368) begin miscompares++; $display("FAIL abort_result: got %0d expected 46368", result); end
    seen = 0;
    repeat (25) begin @(negedge clk); if (done === 1'b1) seen++; end
    vectors++; if (seen != 0) begin miscompares++; $display("FAIL abort_no_done: got %0d pulses expected 0", seen); end
    // Abort lands on the cycle the run would otherwise complete.
    @(negedge clk); start = 1'b1; mode = 2'b00; n = 5'd2;
    @(negedge clk); start = 1'b0;
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL abort_prio_done: got %b expected 0", done); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_prio_busy: got %b expected 0", busy); end
    vectors++; if (result !== 16'd46368) begin miscompares++; $display("FAIL abort_prio_result: got %0d expected 46368", result); end
    abort = 1'b1;
    repeat (3) @(negedge clk);
    abort = 1'b0;
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL abort_idle: got busy=%b done=%b expected 0 0", busy, done); end
  endtask

  task automatic test_start_ignored();
    int lat;
    @(negedge clk); start = 1'b1; mode = 2'b00; n = 5'd10;
    @(negedge clk); start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (lat == 3) begin start = 1'b1; mode = 2'b10; n = 5'd3; end
      else start = 1'b0;
      @(negedge clk);
      lat++;
    end
    vectors++; if (lat != 10) begin miscompares++; $display("FAIL busy_start_latency: got %0d expected 10", lat); end
    vectors++; if (result !== 16'd55) begin miscompares++; $display("FAIL busy_start_result: got %0d expected 55", result); end
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL done_start_ignored: got %b expected 0", busy); end
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL start_not_queued: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt;
    do_run(2'b00, 5'd7, 16'h0, 16'h0, lat, bcnt);
    vectors++; if (result !== 16'd13) begin miscompares++; $display("FAIL b2b_first_result: got %0d expected 13", result); end
    do_run(2'b10, 5'd4, 16'h0, 16'h0, lat, bcnt);
    vectors++; if (result !== 16'd12) begin miscompares++; $display("FAIL b2b_second_result: got %0d expected 12", result); end
    vectors++; if (lat != 4) begin miscompares++; $display("FAIL b2b_second_latency: got %0d expected 4", lat); end
  endtask

  task automatic test_reset_mid();
    int lat, bcnt, seen;
    @(negedge clk); start = 1'b1; mode = 2'b00; n = 5'd20;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL midreset_done: got %b expected 0", done); end
    vectors++; if (result !== 16'd0) begin miscompares++; $display("FAIL midreset_result: got %0d expected 0", result); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL midreset_overflow: got %b expected 0", overflow); end
    seen = 0;
    repeat (25) begin @(negedge clk); if (done === 1'b1 || busy === 1'b1) seen++; end
    vectors++; if (seen != 0) begin miscompares++; $display("FAIL midreset_discard: got %0d active cycles expected 0", seen); end
    do_run(2'b00, 5'd7, 16'h0, 16'h0, lat, bcnt);
    vectors++; if (result !== 16'd13) begin miscompares++; $display("FAIL post_reset_fib7: got %0d expected 13", result); end
    vectors++; if (lat != 7) begin miscompares++; $display("FAIL post_reset_latency: got %0d expected 7", lat); end
  endtask

  initial begin
    test_reset();
    test_fibonacci();
    test_other_modes();
    test_overflow();
    test_abort();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
